spart_driver: RTL

Bus-master controller for the SPART. After reset it programs the baud divisor from the board `br_cfg` switches, then runs an echo loop: it reads each received byte out of the SPART, queues it in an internal FIFO and writes it back to the transmit buffer when `tbr` permits. It sits between the board switches and the SPART I/O bus and is the only master of `iocs`/`iorw`/`ioaddr`/`databus`.

---
 rtl/spart_driver_if.sv | 12 +
 rtl/spart_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spart_driver_if.sv
// SPART I/O control and handshake bundle between the bus-master driver and the SPART.
// The 8-bit data bus is tri-state and is carried as a separate inout port on the driver.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes received
// bytes back to the transmitter through a small circular FIFO.
//
// state  | meaning
// CFG_LO | write divisor low byte to ioaddr 10
// CFG_HI | write divisor high byte to ioaddr 11, record active config
// IDLE   | pick next action: reconfigure > read > write > wait
// RD     | read one byte from ioaddr 00 into the FIFO
// WR     | write the FIFO head to ioaddr 00
// GAP    | one quiet cycle so rda/tbr can settle after an access
module spart_driver #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_4800   = 16'h028A,
  parameter logic [15:0] DIV_9600   = 16'h0145,
  parameter logic [15:0] DIV_19200  = 16'h00A2,
  parameter logic [15:0] DIV_38400  = 16'h0050
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  spart_driver_if.master                bus,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, GAP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cfg_sel;
  logic [1:0]    cfg_active;
  logic [15:0]   div;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          iocs, iorw, drive, push, pop;
  logic [1:0]    ioaddr;
  logic [7:0]    dout;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    case (cfg_sel)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_LO;
      cfg_sel    <= br_cfg;
      cfg_active <= 2'b00;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == CFG_LO)
        cfg_sel <= br_cfg;
      // Record the value actually programmed, so a br_cfg change during
      // configuration is caught by the next IDLE comparison.
      if (state == CFG_HI)
        cfg_active <= cfg_sel;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= databus;
  end

  always_comb begin
    state_nxt = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    drive     = 1'b0;
    dout      = 8'h00;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      CFG_LO: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        ioaddr    = 2'b10;
        drive     = 1'b1;
        dout      = div[7:0];
        state_nxt = CFG_HI;
      end
      CFG_HI: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        ioaddr    = 2'b11;
        drive     = 1'b1;
        dout      = div[15:8];
        state_nxt = GAP;
      end
      IDLE: begin
        if (br_cfg != cfg_active)
          state_nxt = CFG_LO;
        else if (bus.rda && !full)
          state_nxt = RD;
        else if (bus.tbr && !empty)
          state_nxt = WR;
      end
      RD: begin
        iocs      = 1'b1;
        push      = 1'b1;
        state_nxt = GAP;
      end
      WR: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        drive     = 1'b1;
        dout      = mem[rd_ptr];
        pop       = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = CFG_LO;
    endcase
    // While reset is held the state already reads CFG_LO; keep the bus quiet.
    if (rst) begin
      iocs   = 1'b0;
      iorw   = 1'b1;
      ioaddr = 2'b00;
      drive  = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
    end
  end

  assign bus.iocs   = iocs;
  assign bus.iorw   = iorw;
  assign bus.ioaddr = ioaddr;
  assign databus    = drive ? dout : 8'hzz;
  assign fifo_count = count;

endmodule
